extensor_imediato: RTL

Parametrised, clocked immediate extender for the 8-bit datapath. It generalises fixed 3→8 sign extension. It accepts an immediate as one or more IN_W-bit chunks through a valid/ready handshake and concatenates them MSB-first. It then zero-extends, sign-extends or negates the result to OUT_W bits and holds it until the consumer takes it. It sits between instruction decode and the ALU operand mux, so short instruction fields can build wider constants over consecutive prefix instructions.

---
 rtl/extensor_pkg.sv | 22 ++
 rtl/extensor_sinal.sv | 33 +++
 rtl/extensor_imediato.sv | 96 +++++++++
 3 files changed

// File: rtl/extensor_pkg.sv
// Shared constants, FSM state type and sizing helper
// for the chunked immediate extender.
package extensor_pkg;

  localparam logic [1:0] MODO_ZERO  = 2'b00;
  localparam logic [1:0] MODO_SINAL = 2'b01;
  localparam logic [1:0] MODO_NEGA  = 2'b10;

  typedef enum logic [1:0] {
    OCIOSO,
    ACUMULA,
    RESULTADO
  } estado_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/extensor_sinal.sv
// Extends the low n bits of acc to OUT_W bits
// (zero, sign, or sign then two's-complement negate).
module extensor_sinal
  import extensor_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int NW    = 4
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [NW-1:0]    n,
  input  logic [1:0]       modo,
  output logic [OUT_W-1:0] y
);

  logic [OUT_W-1:0] x;
  logic             sb;
  logic             sinal;

  assign sinal = (modo == MODO_SINAL) || (modo == MODO_NEGA);

  always_comb begin
    sb = 1'b0;
    x  = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i == int'(n) - 1) sb = acc[i];
    end
    for (int i = 0; i < OUT_W; i++) begin
      x[i] = (i < int'(n)) ? acc[i] : (sb & sinal);
    end
    y = (modo == MODO_NEGA) ? (~x + OUT_W'(1)) : x;
  end

endmodule

// File: rtl/extensor_imediato.sv
// Accumulates IN_W-bit immediate chunks MSB-first and
// presents the extended OUT_W-bit result via valid/ready.
module extensor_imediato
  import extensor_pkg::*;
#(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 8,
  parameter int MAX_CHUNKS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valido_entrada,
  output logic             pronto_entrada,
  input  logic [IN_W-1:0]  entrada,
  input  logic             ultimo,
  input  logic [1:0]       modo,
  output logic             valido_saida,
  input  logic             pronto_saida,
  output logic [OUT_W-1:0] saida,
  output logic             estouro
);

  localparam int MAX_BITS = MAX_CHUNKS * IN_W;
  localparam int NB_W     = clog2(MAX_BITS + 1);
  localparam int NW       = clog2(OUT_W + 1);

  estado_t                 estado;
  logic [OUT_W-1:0]        acc;
  logic [OUT_W-1:0]        acc_nxt;
  logic [OUT_W+IN_W-1:0]   cat;
  logic [NB_W-1:0]         nbits;
  logic [NB_W-1:0]         nbits_nxt;
  logic [NB_W:0]           soma;
  logic                    estouro_nxt;
  logic [1:0]              modo_q;
  logic [1:0]              modo_ef;
  logic [NW-1:0]           n;
  logic [OUT_W-1:0]        ext;
  logic                    aceita;

  assign pronto_entrada = (estado != RESULTADO);
  assign aceita = valido_entrada && pronto_entrada;

  assign cat     = {acc, entrada};
  assign acc_nxt = cat[OUT_W-1:0];

  assign soma = {1'b0, nbits} + (NB_W+1)'(IN_W);
  assign nbits_nxt = (soma > (NB_W+1)'(MAX_BITS))
                   ? NB_W'(MAX_BITS) : soma[NB_W-1:0];

  // Once past OUT_W the top bits are gone; extend from bit OUT_W-1.
  assign estouro_nxt = nbits_nxt > NB_W'(OUT_W);
  assign n = estouro_nxt ? NW'(OUT_W) : nbits_nxt[NW-1:0];

  assign modo_ef = (estado == OCIOSO) ? modo : modo_q;

  extensor_sinal #(
    .OUT_W (OUT_W),
    .NW    (NW)
  ) u_sinal (
    .acc  (acc_nxt),
    .n    (n),
    .modo (modo_ef),
    .y    (ext)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      acc          <= '0;
      nbits        <= '0;
      modo_q       <= MODO_ZERO;
      saida        <= '0;
      estouro      <= 1'b0;
      valido_saida <= 1'b0;
    end else if (aceita) begin
      acc   <= acc_nxt;
      nbits <= nbits_nxt;
      if (estado == OCIOSO) modo_q <= modo;
      if (ultimo) begin
        saida        <= ext;
        estouro      <= estouro_nxt;
        valido_saida <= 1'b1;
        estado       <= RESULTADO;
      end else begin
        estado <= ACUMULA;
      end
    end else if (estado == RESULTADO && pronto_saida) begin
      valido_saida <= 1'b0;
      acc          <= '0;
      nbits        <= '0;
      estado       <= OCIOSO;
    end
  end

endmodule
